// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: alu opcodes, operand width and the registered result bundle
package alu_share_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 5'b00000,
        OP_SUB = 5'b00001,
        OP_AND = 5'b00010,
        OP_OR  = 5'b00011,
        OP_SLL = 5'b00100,
        OP_SRA = 5'b00101
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              ne;
        logic              lt;
        logic              ovf;
    } alu_out_t;

    function automatic logic op_known(input logic [OP_W-1:0] op);
        return op <= OP_SRA;
    endfunction

    function automatic logic op_arith(input logic [OP_W-1:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle for the two requesters of the shared alu
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [OP_W-1:0]      req_opcode_0;
    logic [OP_W-1:0]      req_opcode_1;
    logic [4:0]           req_shamt_0;
    logic [4:0]           req_shamt_1;
    logic [DATA_W-1:0]    req_opa_0;
    logic [DATA_W-1:0]    req_opa_1;
    logic [DATA_W-1:0]    req_opb_0;
    logic [DATA_W-1:0]    req_opb_1;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [DATA_W-1:0]    resp_result_0;
    logic [DATA_W-1:0]    resp_result_1;
    logic                 resp_ne_0;
    logic                 resp_ne_1;
    logic                 resp_lt_0;
    logic                 resp_lt_1;
    logic                 resp_ovf_0;
    logic                 resp_ovf_1;
    logic [CNT_WIDTH-1:0] grant_cnt_0;
    logic [CNT_WIDTH-1:0] grant_cnt_1;

    modport master (
        output req_valid, req_opcode_0, req_opcode_1, req_shamt_0, req_shamt_1,
               req_opa_0, req_opa_1, req_opb_0, req_opb_1, resp_ready,
        input  req_ready, resp_valid, resp_result_0, resp_result_1, resp_ne_0, resp_ne_1,
               resp_lt_0, resp_lt_1, resp_ovf_0, resp_ovf_1, grant_cnt_0, grant_cnt_1
    );

    modport slave (
        input  req_valid, req_opcode_0, req_opcode_1, req_shamt_0, req_shamt_1,
               req_opa_0, req_opa_1, req_opb_0, req_opb_1, resp_ready,
        output req_ready, resp_valid, resp_result_0, resp_result_1, resp_ne_0, resp_ne_1,
               resp_lt_0, resp_lt_1, resp_ovf_0, resp_ovf_1, grant_cnt_0, grant_cnt_1
    );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// alu_share_arbiter_alu: 32-bit combinational alu with compare flags and raw overflow
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output alu_out_t          alu_o
);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    // result select plus flags; overflow is reported for add or sub and masked by the caller
    always_comb begin
        sum          = op_a + op_b;
        diff         = op_a - op_b;
        alu_o.ne     = op_a != op_b;
        alu_o.lt     = $signed(op_a) < $signed(op_b);
        alu_o.ovf    = opcode == OP_SUB ?
                       (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]) :
                       (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
        alu_o.result = opcode == OP_ADD ? sum :
                       opcode == OP_SUB ? diff :
                       opcode == OP_AND ? op_a & op_b :
                       opcode == OP_OR  ? op_a | op_b :
                       opcode == OP_SLL ? op_a << shamt :
                       opcode == OP_SRA ? DATA_W'($signed(op_a) >>> shamt) : '0;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one alu between two requesters with per-port registered response slots
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter bit RR_EN     = 1'b1,
    parameter int CNT_WIDTH = 16
)(
    input logic                 clk,
    input logic                 rst,
    alu_share_arbiter_if.slave  bus
);
    logic [1:0]           elig;
    logic [1:0]           gnt;
    logic                 ptr_q, ptr_d;
    logic [1:0]           resp_valid_q, resp_valid_d;
    alu_out_t             slot_q [2];
    alu_out_t             slot_d [2];
    logic [CNT_WIDTH-1:0] cnt_q [2];
    logic [CNT_WIDTH-1:0] cnt_d [2];
    logic [OP_W-1:0]      op;
    logic [4:0]           shamt;
    logic [DATA_W-1:0]    op_a, op_b;
    alu_out_t             alu_o, res;

    // arbitration and operand mux; ready never looks at the request payload
    always_comb begin
        elig   = bus.req_valid & (~resp_valid_q | bus.resp_ready);
        gnt[0] = elig[0] & (~elig[1] | ~RR_EN | ~ptr_q);
        gnt[1] = elig[1] & (~elig[0] | (RR_EN & ptr_q));
        ptr_d  = (RR_EN && &elig) ? ~ptr_q : ptr_q;
        op     = gnt[1] ? bus.req_opcode_1 : bus.req_opcode_0;
        shamt  = gnt[1] ? bus.req_shamt_1  : bus.req_shamt_0;
        op_a   = gnt[1] ? bus.req_opa_1    : bus.req_opa_0;
        op_b   = gnt[1] ? bus.req_opb_1    : bus.req_opb_0;
    end

    alu_share_arbiter_alu u_alu (
        .opcode (op),
        .shamt  (shamt),
        .op_a   (op_a),
        .op_b   (op_b),
        .alu_o  (alu_o)
    );

    // slot and counter next state; unknown opcodes never see the alu output
    always_comb begin
        res = op_known(op) ? {alu_o.result, alu_o.ne, alu_o.lt, alu_o.ovf & op_arith(op)} : '0;
        resp_valid_d = gnt | (resp_valid_q & ~bus.resp_ready);
        for (int k = 0; k < 2; k++) begin
            slot_d[k] = gnt[k] ? res : slot_q[k];
            cnt_d[k]  = (gnt[k] && cnt_q[k] != '1) ? cnt_q[k] + 1'b1 : cnt_q[k];
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            resp_valid_q <= '0;
            for (int k = 0; k < 2; k++) begin
                slot_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            for (int k = 0; k < 2; k++) begin
                slot_q[k] <= slot_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign bus.req_ready     = gnt;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_result_0 = slot_q[0].result;
    assign bus.resp_result_1 = slot_q[1].result;
    assign bus.resp_ne_0     = slot_q[0].ne;
    assign bus.resp_ne_1     = slot_q[1].ne;
    assign bus.resp_lt_0     = slot_q[0].lt;
    assign bus.resp_lt_1     = slot_q[1].lt;
    assign bus.resp_ovf_0    = slot_q[0].ovf;
    assign bus.resp_ovf_1    = slot_q[1].ovf;
    assign bus.grant_cnt_0   = cnt_q[0];
    assign bus.grant_cnt_1   = cnt_q[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: round-robin and fixed-priority instances checked against a reference model
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.CNT_WIDTH(2))  ifa ();
    alu_share_arbiter_if #(.CNT_WIDTH(16)) ifb ();

    alu_share_arbiter #(.RR_EN(1'b1), .CNT_WIDTH(2))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
    alu_share_arbiter #(.RR_EN(1'b0), .CNT_WIDTH(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // stimulus per instance d and port k
    logic        pv  [2][2];
    logic        prr [2][2];
    logic [4:0]  pop [2][2];
    logic [4:0]  psh [2][2];
    logic [31:0] pa  [2][2];
    logic [31:0] pb  [2][2];

    assign ifa.req_valid    = {pv[0][1], pv[0][0]};
    assign ifa.resp_ready   = {prr[0][1], prr[0][0]};
    assign ifa.req_opcode_0 = pop[0][0];
    assign ifa.req_opcode_1 = pop[0][1];
    assign ifa.req_shamt_0  = psh[0][0];
    assign ifa.req_shamt_1  = psh[0][1];
    assign ifa.req_opa_0    = pa[0][0];
    assign ifa.req_opa_1    = pa[0][1];
    assign ifa.req_opb_0    = pb[0][0];
    assign ifa.req_opb_1    = pb[0][1];
    assign ifb.req_valid    = {pv[1][1], pv[1][0]};
    assign ifb.resp_ready   = {prr[1][1], prr[1][0]};
    assign ifb.req_opcode_0 = pop[1][0];
    assign ifb.req_opcode_1 = pop[1][1];
    assign ifb.req_shamt_0  = psh[1][0];
    assign ifb.req_shamt_1  = psh[1][1];
    assign ifb.req_opa_0    = pa[1][0];
    assign ifb.req_opa_1    = pa[1][1];
    assign ifb.req_opb_0    = pb[1][0];
    assign ifb.req_opb_1    = pb[1][1];

    // observed outputs gathered per instance
    logic [1:0]  o_rdy [2];
    logic [1:0]  o_vld [2];
    logic [31:0] o_res [2][2];
    logic        o_ne  [2][2];
    logic        o_lt  [2][2];
    logic        o_ovf [2][2];
    logic [15:0] o_cnt [2][2];

    assign o_rdy[0]    = ifa.req_ready;
    assign o_vld[0]    = ifa.resp_valid;
    assign o_res[0][0] = ifa.resp_result_0;
    assign o_res[0][1] = ifa.resp_result_1;
    assign o_ne[0][0]  = ifa.resp_ne_0;
    assign o_ne[0][1]  = ifa.resp_ne_1;
    assign o_lt[0][0]  = ifa.resp_lt_0;
    assign o_lt[0][1]  = ifa.resp_lt_1;
    assign o_ovf[0][0] = ifa.resp_ovf_0;
    assign o_ovf[0][1] = ifa.resp_ovf_1;
    assign o_cnt[0][0] = 16'(ifa.grant_cnt_0);
    assign o_cnt[0][1] = 16'(ifa.grant_cnt_1);
    assign o_rdy[1]    = ifb.req_ready;
    assign o_vld[1]    = ifb.resp_valid;
    assign o_res[1][0] = ifb.resp_result_0;
    assign o_res[1][1] = ifb.resp_result_1;
    assign o_ne[1][0]  = ifb.resp_ne_0;
    assign o_ne[1][1]  = ifb.resp_ne_1;
    assign o_lt[1][0]  = ifb.resp_lt_0;
    assign o_lt[1][1]  = ifb.resp_lt_1;
    assign o_ovf[1][0] = ifb.resp_ovf_0;
    assign o_ovf[1][1] = ifb.resp_ovf_1;
    assign o_cnt[1][0] = ifb.grant_cnt_0;
    assign o_cnt[1][1] = ifb.grant_cnt_1;

    // reference model state
    int          rr_en [2] = '{1, 0};
    int          cmax  [2] = '{3, 65535};
    logic        mv    [2][2];
    logic [31:0] mres  [2][2];
    logic        mne   [2][2];
    logic        mlt   [2][2];
    logic        movf  [2][2];
    int          mcnt  [2][2];
    logic        mg    [2][2];
    int          mturn [2];
    logic        mboth [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void ref_alu(input logic [4:0] op, input logic [4:0] sh, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r, output logic ne,
                                    output logic lt, output logic ov);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = '0;
        ne = 1'b0;
        lt = 1'b0;
        ov = 1'b0;
        if (op > 5'd5) return;
        ne = a != b;
        lt = sa < sb;
        case (op)
            5'd0:    s = sa + sb;
            5'd1:    s = sa - sb;
            5'd2:    s = longint'(a & b);
            5'd3:    s = longint'(a | b);
            5'd4:    s = longint'(a) << sh;
            default: s = sa >>> sh;
        endcase
        r  = s[31:0];
        ov = (op <= 5'd1) && (s != longint'($signed(r)));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mturn[d] = 0;
            mboth[d] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mv[d][k] = 1'b0; mres[d][k] = '0; mne[d][k] = 1'b0; mlt[d][k] = 1'b0;
                movf[d][k] = 1'b0; mcnt[d][k] = 0; mg[d][k] = 1'b0;
            end
        end
    endtask

    task automatic model_grant(input int d);
        logic el0, el1;
        int   w;
        el0 = pv[d][0] && (!mv[d][0] || prr[d][0]);
        el1 = pv[d][1] && (!mv[d][1] || prr[d][1]);
        mboth[d] = el0 && el1;
        w = rr_en[d] != 0 ? mturn[d] : 0;
        mg[d][0] = el0 && (!el1 || w == 0);
        mg[d][1] = el1 && (!el0 || w == 1);
    endtask

    task automatic model_commit(input int d);
        for (int k = 0; k < 2; k++) begin
            if (mg[d][k]) begin
                ref_alu(pop[d][k], psh[d][k], pa[d][k], pb[d][k], mres[d][k], mne[d][k], mlt[d][k], movf[d][k]);
                mv[d][k] = 1'b1;
                if (mcnt[d][k] < cmax[d]) mcnt[d][k]++;
            end else if (prr[d][k]) begin
                mv[d][k] = 1'b0;
            end
        end
        if (rr_en[d] != 0 && mboth[d]) mturn[d] = 1 - mturn[d];
    endtask

    task automatic check_outputs(input int d);
        check($sformatf("d%0d_req_ready", d), o_rdy[d], {mg[d][1], mg[d][0]});
        check($sformatf("d%0d_resp_valid", d), o_vld[d], {mv[d][1], mv[d][0]});
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d_result_%0d", d, k), o_res[d][k], mres[d][k]);
            check($sformatf("d%0d_ne_%0d", d, k), o_ne[d][k], mne[d][k]);
            check($sformatf("d%0d_lt_%0d", d, k), o_lt[d][k], mlt[d][k]);
            check($sformatf("d%0d_ovf_%0d", d, k), o_ovf[d][k], movf[d][k]);
            check($sformatf("d%0d_grant_cnt_%0d", d, k), o_cnt[d][k], 64'(mcnt[d][k]));
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int d = 0; d < 2; d++) model_grant(d);
        for (int d = 0; d < 2; d++) check_outputs(d);
    endtask

    task automatic advance();
        for (int d = 0; d < 2; d++) model_commit(d);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) model_grant(d);
        for (int d = 0; d < 2; d++) check_outputs(d);
        for (int d = 0; d < 2; d++) begin mg[d][0] = 1'b0; mg[d][1] = 1'b0; end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_both(input int k, input logic v, input logic [4:0] op, input logic [4:0] sh,
                            input logic [31:0] a, input logic [31:0] b);
        for (int d = 0; d < 2; d++) begin
            pv[d][k] = v; pop[d][k] = op; psh[d][k] = sh; pa[d][k] = a; pb[d][k] = b;
        end
    endtask

    task automatic set_rr(input int k, input logic v);
        for (int d = 0; d < 2; d++) prr[d][k] = v;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 3));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic new_req(input int d, input int k);
        pv[d][k]  = $urandom_range(0, 3) != 0;
        pop[d][k] = 5'($urandom_range(0, 9));
        psh[d][k] = 5'($urandom);
        pa[d][k]  = pick();
        pb[d][k]  = pick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++) begin
                pv[d][k] = 1'b0; prr[d][k] = 1'b0; pop[d][k] = '0; psh[d][k] = '0; pa[d][k] = '0; pb[d][k] = '0;
            end
        apply_reset();
        sample();
        check("reset_valid", o_vld[0], 2'b00);
        check("reset_cnt0", o_cnt[0][0], 0);
        advance();

        // single add
        set_rr(0, 1'b1);
        set_rr(1, 1'b1);
        set_both(0, 1'b1, 5'd0, 5'd0, 32'd5, 32'd7);
        sample();
        check("t1_ready", o_rdy[0][0], 1'b1);
        advance();
        set_both(0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        sample();
        check("t1_valid", o_vld[0][0], 1'b1);
        check("t1_result", o_res[0][0], 32'd12);
        check("t1_ne", o_ne[0][0], 1'b1);
        check("t1_lt", o_lt[0][0], 1'b1);
        check("t1_ovf", o_ovf[0][0], 1'b0);
        advance();

        // contention: alternating on the round-robin instance, port 0 always on the fixed one
        apply_reset();
        set_both(0, 1'b1, 5'd0, 5'd0, 32'd1, 32'd2);
        set_both(1, 1'b1, 5'd1, 5'd0, 32'd3, 32'd3);
        for (int i = 0; i < 4; i++) begin
            sample();
            check("t2_rr_grant", o_rdy[0], (i % 2) != 0 ? 2'b10 : 2'b01);
            check("t2_fixed_grant", o_rdy[1], 2'b01);
            advance();
        end
        set_both(0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        set_both(1, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        sample();
        check("t2_cnt0", o_cnt[0][0], 2);
        check("t2_cnt1", o_cnt[0][1], 2);
        check("t2_sub_result", o_res[0][1], 32'd0);
        check("t2_sub_ne", o_ne[0][1], 1'b0);
        advance();

        // backpressure on port 0
        set_rr(0, 1'b0);
        set_both(0, 1'b1, 5'd3, 5'd0, 32'hF0, 32'h0F);
        sample();
        check("t3_accept1", o_rdy[0][0], 1'b1);
        advance();
        set_both(0, 1'b1, 5'd4, 5'd4, 32'd1, 32'd9);
        sample();
        check("t3_stall", o_rdy[0][0], 1'b0);
        check("t3_res1", o_res[0][0], 32'hFF);
        advance();
        sample();
        check("t3_hold_res", o_res[0][0], 32'hFF);
        check("t3_hold_valid", o_vld[0][0], 1'b1);
        advance();
        set_rr(0, 1'b1);
        sample();
        check("t3_accept2", o_rdy[0][0], 1'b1);
        advance();
        set_both(0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        sample();
        check("t3_b2b_valid", o_vld[0][0], 1'b1);
        check("t3_res2", o_res[0][0], 32'd16);
        advance();

        // overflow masking and unknown opcode
        set_both(0, 1'b1, 5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1);
        sample();
        advance();
        set_both(0, 1'b1, 5'd2, 5'd0, 32'h7FFF_FFFF, 32'd1);
        sample();
        check("t4_add_res", o_res[0][0], 32'h8000_0000);
        check("t4_add_ovf", o_ovf[0][0], 1'b1);
        advance();
        set_both(0, 1'b1, 5'd8, 5'd3, 32'h7FFF_FFFF, 32'd1);
        sample();
        check("t4_and_res", o_res[0][0], 32'd1);
        check("t4_and_ovf", o_ovf[0][0], 1'b0);
        advance();
        set_both(0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        sample();
        check("t4_bad_res", o_res[0][0], 32'd0);
        check("t4_bad_flags", {o_ne[0][0], o_lt[0][0], o_ovf[0][0]}, 3'b000);
        advance();

        // reset while port 0 is granted and slot 1 is full, with the pointer at port 1
        set_rr(1, 1'b0);
        set_both(0, 1'b1, 5'd0, 5'd0, 32'd2, 32'd2);
        set_both(1, 1'b1, 5'd1, 5'd0, 32'd9, 32'd4);
        sample();
        advance();
        set_both(0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        sample();
        advance();
        set_both(0, 1'b1, 5'd3, 5'd0, 32'd6, 32'd1);
        set_both(1, 1'b1, 5'd2, 5'd0, 32'd7, 32'd5);
        sample();
        check("t5_slot1_full", o_vld[0][1], 1'b1);
        check("t5_port0_grant", o_rdy[0], 2'b01);
        apply_reset();
        check("t5_valid_clr", o_vld[0], 2'b00);
        check("t5_cnt0_clr", o_cnt[0][0], 0);
        check("t5_cnt1_clr", o_cnt[0][1], 0);
        set_rr(1, 1'b1);
        sample();
        check("t5_ptr_reset", o_rdy[0], 2'b01);
        advance();

        // saturation on the 2-bit counters
        apply_reset();
        set_both(0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_both(1, 1'b1, 5'd0, 5'd0, 32'(i), 32'(i));
            sample();
            check("t6_cnt", o_cnt[0][1], i < 3 ? i : 3);
            advance();
        end
        set_both(1, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        sample();
        check("t6_cnt_sat", o_cnt[0][1], 3);
        advance();

        // randomized traffic
        for (int d = 0; d < 2; d++) for (int k = 0; k < 2; k++) new_req(d, k);
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) for (int k = 0; k < 2; k++) prr[d][k] = $urandom_range(0, 2) != 0;
            sample();
            advance();
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 2; k++)
                    if (mg[d][k] || !pv[d][k]) new_req(d, k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
